// File: rtl/gmii_pkg.sv
// gmii_pkg: shared GMII constants and receive state encoding
package gmii_pkg;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
    localparam logic [1:0]  SPEED_1000    = 2'b10;
    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} rx_state_t;
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: one-byte reflected CRC-32 update, LSB first
module crc32_d8
    import gmii_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);
    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++)
            crc_next = (crc_next[0] ^ data[i]) ? (crc_next >> 1) ^ CRC32_POLY : crc_next >> 1;
    end
endmodule

// File: rtl/gmii_rx_deframer.sv
// gmii_rx_deframer: strips preamble/SFD, assembles nibbles, emits frame bytes with CRC/length status
module gmii_rx_deframer
    import gmii_pkg::*;
#(
    parameter int MAX_LEN = 1522,
    parameter int MIN_LEN = 64
) (
    input  logic        rx_clk,
    input  logic        rst,
    input  logic [1:0]  speed,
    input  logic [7:0]  rx_data,
    input  logic        rx_dv,
    input  logic        rx_er,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_err,
    output logic        crc_ok,
    output logic [15:0] frame_len
);
    rx_state_t   state, state_nx;
    logic        dv_q, byte_mode, nib_ph, have_hold, sof_pend, eof_pend, er;
    logic        accept, dv_fall, pre_ok, sfd_ok, crc_good, len_bad;
    logic [1:0]  spd_l;
    logic [3:0]  nib_lo;
    logic [7:0]  hold, in_byte;
    logic [15:0] len;
    logic [31:0] crc, crc_nx;

    crc32_d8 u_crc (.crc(crc), .data(in_byte), .crc_next(crc_nx));

    always_comb begin
        byte_mode = spd_l == SPEED_1000;
        in_byte   = byte_mode ? rx_data : {rx_data[3:0], nib_lo};
        accept    = state == DATA && rx_dv && (byte_mode || nib_ph);
        dv_fall   = state == DATA && !rx_dv;
        pre_ok    = byte_mode ? rx_data == PREAMBLE_BYTE : rx_data[3:0] == PREAMBLE_BYTE[3:0];
        sfd_ok    = byte_mode ? rx_data == SFD_BYTE : rx_data[3:0] == SFD_BYTE[7:4];
        crc_good  = crc == CRC32_RESIDUE;
        len_bad   = 32'(len) < MIN_LEN || 32'(len) > MAX_LEN;
        state_nx  = state;
        case (state)
            IDLE:    state_nx = !dv_q && rx_dv ? PRE : IDLE;
            PRE:     state_nx = !rx_dv ? IDLE : sfd_ok ? DATA : pre_ok ? PRE : DROP;
            DATA:    state_nx = rx_dv ? DATA : IDLE;
            default: state_nx = rx_dv ? DROP : IDLE;
        endcase
    end

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // In nibble mode the eof beat slips one cycle if it would abut the previous beat
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            dv_q      <= 1'b1;
            spd_l     <= 2'b00;
            nib_ph    <= 1'b0;
            nib_lo    <= '0;
            hold      <= '0;
            have_hold <= 1'b0;
            sof_pend  <= 1'b0;
            eof_pend  <= 1'b0;
            er        <= 1'b0;
            len       <= '0;
            crc       <= CRC32_INIT;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_err   <= 1'b0;
            crc_ok    <= 1'b0;
            frame_len <= '0;
        end else begin
            dv_q      <= rx_dv;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            eof_pend  <= 1'b0;
            if (state == IDLE && state_nx == PRE)
                spd_l <= speed;
            if (state == PRE && state_nx == DATA) begin
                crc       <= CRC32_INIT;
                len       <= '0;
                er        <= 1'b0;
                nib_ph    <= 1'b0;
                have_hold <= 1'b0;
                sof_pend  <= 1'b1;
            end
            if (state == DATA && rx_dv) begin
                er     <= er | rx_er;
                nib_ph <= !byte_mode && !nib_ph;
                nib_lo <= nib_ph ? nib_lo : rx_data[3:0];
            end
            if (accept) begin
                crc       <= crc_nx;
                len       <= len + 16'(len != 16'hFFFF);
                hold      <= in_byte;
                have_hold <= 1'b1;
                out_valid <= have_hold;
                out_sof   <= have_hold && sof_pend;
                out_data  <= have_hold ? hold : out_data;
                sof_pend  <= sof_pend && !have_hold;
            end
            if (dv_fall && have_hold) begin
                crc_ok    <= crc_good;
                frame_len <= len;
                out_err   <= er | !crc_good | nib_ph | len_bad;
                have_hold <= 1'b0;
                eof_pend  <= !byte_mode && out_valid;
                if (byte_mode || !out_valid) begin
                    out_valid <= 1'b1;
                    out_sof   <= sof_pend;
                    out_eof   <= 1'b1;
                    out_data  <= hold;
                    sof_pend  <= 1'b0;
                end
            end
            if (eof_pend) begin
                out_valid <= 1'b1;
                out_sof   <= sof_pend;
                out_eof   <= 1'b1;
                out_data  <= hold;
                sof_pend  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gmii_rx_deframer.sv
// tb_gmii_rx_deframer: directed self-checking bench for the GMII receive deframer
module tb_gmii_rx_deframer;
    logic        rx_clk = 1'b0, rst = 1'b1;
    logic [1:0]  speed = 2'b10;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_dv = 1'b0, rx_er = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid, out_sof, out_eof, out_err, crc_ok;
    logic [15:0] frame_len;
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    logic [7:0]  frm [0:1599];
    logic [7:0]  got [0:4095];
    logic        sof_a [0:4095];
    logic        eof_a [0:4095];
    int          n_got = 0, n_eof = 0, n_strobe = 0, n_consec = 0, last_eof_cyc = 0;
    logic        last_crc = 1'b0, last_err = 1'b0, prev_v = 1'b0;
    logic [15:0] last_len = 16'h0;

    gmii_rx_deframer dut (
        .rx_clk(rx_clk), .rst(rst), .speed(speed), .rx_data(rx_data), .rx_dv(rx_dv), .rx_er(rx_er),
        .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
        .out_err(out_err), .crc_ok(crc_ok), .frame_len(frame_len)
    );

    always #5 rx_clk = ~rx_clk;
    always @(posedge rx_clk) cyc <= cyc + 1;

    always @(negedge rx_clk) begin
        if (out_valid && n_got < 4096) begin
            got[n_got] = out_data;
            sof_a[n_got] = out_sof;
            eof_a[n_got] = out_eof;
        end
        if (out_valid) n_got++;
        if (out_valid && out_eof) begin
            n_eof++;
            last_crc = crc_ok;
            last_err = out_err;
            last_len = frame_len;
            last_eof_cyc = cyc;
        end
        if ((out_sof || out_eof) && !out_valid) n_strobe++;
        if (out_valid && prev_v) n_consec++;
        prev_v = out_valid;
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : (r >> 1);
        return r;
    endfunction

    function automatic int data_errs(input int base, input int n);
        int e = 0;
        for (int i = 0; i < n; i++)
            if (got[(base + i) % 4096] !== frm[i] || sof_a[(base + i) % 4096] !== (i == 0) ||
                eof_a[(base + i) % 4096] !== (i == n - 1)) e++;
        return e;
    endfunction

    task automatic build_frame(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            frm[i] = 8'(i * 37 + 11);
            c = crc_upd(c, frm[i]);
        end
        c = ~c;
        for (int j = 0; j < 4; j++) frm[n - 4 + j] = c[8*j +: 8];
    endtask

    task automatic tick(input logic dv, input logic [7:0] d, input logic er);
        @(posedge rx_clk);
        #1;
        rx_dv = dv;
        rx_data = d;
        rx_er = er;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_bytes(input int n, input logic [7:0] sfd, input int er_at, output int fc);
        repeat (7) tick(1'b1, 8'h55, 1'b0);
        tick(1'b1, sfd, 1'b0);
        for (int i = 0; i < n; i++) tick(1'b1, frm[i], i == er_at);
        tick(1'b0, 8'h00, 1'b0);
        fc = cyc;
    endtask

    task automatic send_nibs(input int n, input logic dribble, input logic chg, output int fc);
        repeat (15) tick(1'b1, 8'h05, 1'b0);
        tick(1'b1, 8'h0D, 1'b0);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, {4'h0, frm[i][3:0]}, 1'b0);
            if (chg && i == 0) speed = 2'b10;
            tick(1'b1, {4'h0, frm[i][7:4]}, 1'b0);
        end
        if (dribble) tick(1'b1, 8'h0A, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        fc = cyc;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge rx_clk);
        @(negedge rx_clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_sof !== 1'b0 || out_eof !== 1'b0) begin n_bad++; $display("FAIL reset_sof_eof got=%b%b exp=00", out_sof, out_eof); end
        n_cmp++; if (out_err !== 1'b0 || crc_ok !== 1'b0) begin n_bad++; $display("FAIL reset_status got=%b%b exp=00", out_err, crc_ok); end
        n_cmp++; if (frame_len !== 16'h0) begin n_bad++; $display("FAIL reset_len got=%0d exp=0", frame_len); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
        rst = 1'b0;
    endtask

    task automatic test_byte_good;
        int b, e, fc;
        build_frame(64);
        b = n_got; e = n_eof;
        send_bytes(64, 8'hD5, -1, fc);
        idle(3);
        n_cmp++; if (n_got - b !== 64) begin n_bad++; $display("FAIL byte_beats got=%0d exp=64", n_got - b); end
        n_cmp++; if (data_errs(b, 64) !== 0) begin n_bad++; $display("FAIL byte_data bad_beats=%0d exp=0", data_errs(b, 64)); end
        n_cmp++; if (n_eof - e !== 1) begin n_bad++; $display("FAIL byte_eofs got=%0d exp=1", n_eof - e); end
        n_cmp++; if (last_crc !== 1'b1) begin n_bad++; $display("FAIL byte_crc got=%b exp=1", last_crc); end
        n_cmp++; if (last_err !== 1'b0) begin n_bad++; $display("FAIL byte_err got=%b exp=0", last_err); end
        n_cmp++; if (last_len !== 16'd64) begin n_bad++; $display("FAIL byte_len got=%0d exp=64", last_len); end
        n_cmp++; if (last_eof_cyc !== fc + 1) begin n_bad++; $display("FAIL byte_eof_time got=%0d exp=%0d", last_eof_cyc, fc + 1); end
    endtask

    task automatic test_bad_fcs;
        int b, fc;
        build_frame(64);
        frm[60] = frm[60] ^ 8'h01;
        b = n_got;
        send_bytes(64, 8'hD5, -1, fc);
        idle(3);
        n_cmp++; if (n_got - b !== 64) begin n_bad++; $display("FAIL fcs_beats got=%0d exp=64", n_got - b); end
        n_cmp++; if (last_crc !== 1'b0) begin n_bad++; $display("FAIL fcs_crc got=%b exp=0", last_crc); end
        n_cmp++; if (last_err !== 1'b1) begin n_bad++; $display("FAIL fcs_err got=%b exp=1", last_err); end
        n_cmp++; if (last_len !== 16'd64) begin n_bad++; $display("FAIL fcs_len got=%0d exp=64", last_len); end
    endtask

    task automatic test_nibble(input logic dribble);
        int b, c, fc;
        build_frame(64);
        speed = 2'b01;
        b = n_got; c = n_consec;
        send_nibs(64, dribble, !dribble, fc);
        idle(4);
        speed = 2'b10;
        n_cmp++; if (n_got - b !== 64) begin n_bad++; $display("FAIL nib%0d_beats got=%0d exp=64", dribble, n_got - b); end
        n_cmp++; if (data_errs(b, 64) !== 0) begin n_bad++; $display("FAIL nib%0d_data bad_beats=%0d exp=0", dribble, data_errs(b, 64)); end
        n_cmp++; if (n_consec - c !== 0) begin n_bad++; $display("FAIL nib%0d_spacing consecutive=%0d exp=0", dribble, n_consec - c); end
        n_cmp++; if (last_crc !== 1'b1) begin n_bad++; $display("FAIL nib%0d_crc got=%b exp=1", dribble, last_crc); end
        n_cmp++; if (last_err !== dribble) begin n_bad++; $display("FAIL nib%0d_err got=%b exp=%b", dribble, last_err, dribble); end
    endtask

    task automatic test_bad_sfd;
        int b, e, fc;
        build_frame(64);
        b = n_got; e = n_eof;
        send_bytes(20, 8'hD4, -1, fc);
        idle(3);
        n_cmp++; if (n_got - b !== 0) begin n_bad++; $display("FAIL sfd_beats got=%0d exp=0", n_got - b); end
        n_cmp++; if (n_eof - e !== 0) begin n_bad++; $display("FAIL sfd_eofs got=%0d exp=0", n_eof - e); end
    endtask

    task automatic test_rx_er;
        int fc;
        build_frame(64);
        send_bytes(64, 8'hD5, 20, fc);
        idle(3);
        n_cmp++; if (last_err !== 1'b1) begin n_bad++; $display("FAIL rxer_err got=%b exp=1", last_err); end
        n_cmp++; if (last_crc !== 1'b1) begin n_bad++; $display("FAIL rxer_crc got=%b exp=1", last_crc); end
    endtask

    task automatic test_length(input int n);
        int b, fc;
        build_frame(n);
        b = n_got;
        send_bytes(n, 8'hD5, -1, fc);
        idle(3);
        n_cmp++; if (n_got - b !== n) begin n_bad++; $display("FAIL len%0d_beats got=%0d exp=%0d", n, n_got - b, n); end
        n_cmp++; if (data_errs(b, n) !== 0) begin n_bad++; $display("FAIL len%0d_data bad_beats=%0d exp=0", n, data_errs(b, n)); end
        n_cmp++; if (last_len !== 16'(n)) begin n_bad++; $display("FAIL len%0d_len got=%0d exp=%0d", n, last_len, n); end
        n_cmp++; if (last_err !== 1'b1) begin n_bad++; $display("FAIL len%0d_err got=%b exp=1", n, last_err); end
        n_cmp++; if (last_crc !== 1'b1) begin n_bad++; $display("FAIL len%0d_crc got=%b exp=1", n, last_crc); end
    endtask

    task automatic test_reset_mid;
        int b, e, fc;
        build_frame(64);
        b = n_got; e = n_eof;
        repeat (7) tick(1'b1, 8'h55, 1'b0);
        tick(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b1, frm[i], 1'b0);
        @(negedge rx_clk);
        #2;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_valid got=%b exp=1", out_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({out_valid, out_sof, out_eof, out_err, crc_ok} !== 5'b0) begin n_bad++; $display("FAIL rstmid_ctrl got=%b exp=00000", {out_valid, out_sof, out_eof, out_err, crc_ok}); end
        n_cmp++; if (out_data !== 8'h00 || frame_len !== 16'h0) begin n_bad++; $display("FAIL rstmid_data got=%h/%0d exp=00/0", out_data, frame_len); end
        @(negedge rx_clk);
        rst = 1'b0;
        for (int i = 20; i < 64; i++) tick(1'b1, frm[i], 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        idle(2);
        n_cmp++; if (n_got - b !== 18) begin n_bad++; $display("FAIL rstmid_partial got=%0d exp=18", n_got - b); end
        n_cmp++; if (n_eof - e !== 0) begin n_bad++; $display("FAIL rstmid_eofs got=%0d exp=0", n_eof - e); end
        b = n_got;
        send_bytes(64, 8'hD5, -1, fc);
        idle(3);
        n_cmp++; if (data_errs(b, 64) !== 0 || n_got - b !== 64) begin n_bad++; $display("FAIL rstmid_next beats=%0d bad=%0d exp=64/0", n_got - b, data_errs(b, 64)); end
        n_cmp++; if (last_crc !== 1'b1 || last_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_next_status got=%b%b exp=10", last_crc, last_err); end
    endtask

    task automatic test_back_to_back;
        int b, e, fc;
        build_frame(64);
        b = n_got; e = n_eof;
        send_bytes(64, 8'hD5, -1, fc);
        send_bytes(64, 8'hD5, -1, fc);
        idle(3);
        n_cmp++; if (n_got - b !== 128) begin n_bad++; $display("FAIL b2b_beats got=%0d exp=128", n_got - b); end
        n_cmp++; if (n_eof - e !== 2) begin n_bad++; $display("FAIL b2b_eofs got=%0d exp=2", n_eof - e); end
        n_cmp++; if (data_errs(b, 64) + data_errs(b + 64, 64) !== 0) begin n_bad++; $display("FAIL b2b_data bad_beats=%0d exp=0", data_errs(b, 64) + data_errs(b + 64, 64)); end
        n_cmp++; if (last_crc !== 1'b1 || last_err !== 1'b0) begin n_bad++; $display("FAIL b2b_status got=%b%b exp=10", last_crc, last_err); end
    endtask

    task automatic test_strobes;
        n_cmp++; if (n_strobe !== 0) begin n_bad++; $display("FAIL strobes_without_valid got=%0d exp=0", n_strobe); end
    endtask

    initial begin
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) c = crc_upd(c, 8'(8'h31 + i));
        if (~c !== 32'hCBF43926) begin
            $display("FAIL crc_model got=%h exp=cbf43926", ~c);
            $fatal(1);
        end
        test_reset();
        test_byte_good();
        test_bad_fcs();
        test_nibble(1'b0);
        test_nibble(1'b1);
        test_bad_sfd();
        test_rx_er();
        test_length(40);
        test_length(1600);
        test_reset_mid();
        test_back_to_back();
        test_strobes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout sim_time=%0t", $time);
        $fatal(1);
    end
endmodule
